mul_sched: RTL

Multiply sequencer for the CPU's arithmetic path. It accepts a multiply request from the instruction decoder (the `mul_st` strobe with operands and destination register) and runs an iterative shift-add multiply over several cycles. While it is busy it stalls the pipeline. It then presents the product to the register-file write port under a valid/ready handshake. It sits between the decode/operand-fetch stage and the writeback mux, in parallel with the ALU.

---
 rtl/mul_sched.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mul_sched.sv
// mul_sched: iterative shift-add multiply sequencer with a valid/ready writeback port.
// Optional macro MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier
// bits are all zero. The product is unchanged; only latency drops.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for mul_st; operands captured on acceptance
// S_RUN  | one shift-add step per cycle
// S_DONE | product presented on wb_*; held until wb_ready or flush
module mul_sched #(
    parameter int W  = 16,
    parameter int RW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_st,
    input  logic [W-1:0]    op_a,
    input  logic [W-1:0]    op_b,
    input  logic [RW-1:0]   rd_in,
    input  logic            flush,
    input  logic            wb_ready,
    output logic            stall,
    output logic            busy,
    output logic            wb_valid,
    output logic [RW-1:0]   wb_rd,
    output logic [2*W-1:0]  wb_data
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    rd_q, rd_d;
    logic             stall_q, stall_d;
    logic             wb_valid_q, wb_valid_d;
    logic [RW-1:0]    wb_rd_q, wb_rd_d;
    logic [2*W-1:0]   wb_data_q, wb_data_d;
    logic             last_run;

    // Next-state, datapath step, and registered-output next values.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        last_run = (cnt_q == CW'(W - 1));
`ifdef MUL_EARLY_TERM_EN
        last_run = last_run || ((mplier_q >> 1) == '0);
`endif
        case (state_q)
            S_IDLE: begin
                if (mul_st && !flush) begin
                    mcand_d  = {{W{1'b0}}, op_a};
                    mplier_d = op_b;
                    rd_d     = rd_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (last_run) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Flush wins over a simultaneous grant; both leave DONE.
                if (flush || wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they are glitch-free
        // and forced to zero whenever the sequencer is not presenting a product.
        stall_d    = (state_d != S_IDLE);
        wb_valid_d = (state_d == S_DONE);
        wb_data_d  = (state_d == S_DONE) ? acc_d : '0;
        wb_rd_d    = (state_d == S_DONE) ? rd_d  : '0;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            stall_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            stall_q    <= stall_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign stall    = stall_q;
    assign busy     = stall_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule
